// File: rtl/sr_fetch_sched.sv
// Multi-thread instruction fetch scheduler. It keeps one PC per hardware thread and
// issues one instruction per cycle, chosen round-robin or by fixed priority.
module sr_fetch_sched #(
  parameter int          N_THREADS = 2,
  parameter int          ADDR_W    = 32,
  parameter int          ARB_MODE  = 0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  localparam int         TID_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_THREADS*ADDR_W-1:0] start_addr_i,
  input  logic [N_THREADS-1:0]        thr_en_i,
  output logic [N_THREADS*ADDR_W-1:0] im_addr_o,
  input  logic [N_THREADS*32-1:0]     im_data_i,
  input  logic [N_THREADS-1:0]        im_valid_i,
  input  logic                        stall_i,
  input  logic                        br_taken_i,
  input  logic [ADDR_W-1:0]           br_target_i,
  output logic [31:0]                 instr_o,
  output logic                        instr_valid_o,
  output logic [TID_W-1:0]            instr_tid_o,
  output logic [ADDR_W-1:0]           instr_pc_o
);

  typedef enum logic {INIT, RUN} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q [N_THREADS];
  logic [ADDR_W-1:0]    pc_d [N_THREADS];
  logic [TID_W-1:0]     last_q, last_d;
  logic [N_THREADS-1:0] elig;
  logic [TID_W-1:0]     grant;
  logic                 found;
  logic                 issue;

  assign elig  = (state_q == RUN) ? (thr_en_i & im_valid_i) : '0;
  assign issue = found & ~stall_i;

  // With nothing eligible, grant falls back to last_q so the outputs show the last issuer.
  always_comb begin
    grant = last_q;
    found = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = N_THREADS - 1; i >= 0; i--) begin
        if (elig[i]) begin
          grant = TID_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= N_THREADS; k++) begin
        if (!found && elig[(int'(last_q) + k) % N_THREADS]) begin
          grant = TID_W'((int'(last_q) + k) % N_THREADS);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = NOP_INSTR;
    instr_tid_o   = '0;
    instr_pc_o    = '0;
    if (state_q == RUN) begin
      instr_valid_o = issue;
      instr_tid_o   = grant;
      instr_pc_o    = pc_q[grant];
      if (found) begin
        instr_o = im_data_i[int'(grant)*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    case (state_q)
      INIT: begin
        state_d = RUN;
        for (int i = 0; i < N_THREADS; i++) begin
          pc_d[i] = start_addr_i[i*ADDR_W +: ADDR_W];
        end
      end
      RUN: begin
        // Redirect targets are forced word-aligned; sequential fetch wraps naturally.
        if (issue) begin
          pc_d[grant] = br_taken_i ? (br_target_i & ~ADDR_W'(3)) : pc_q[grant] + ADDR_W'(4);
          last_d      = grant;
        end
      end
      default: state_d = INIT;
    endcase
  end

  for (genvar i = 0; i < N_THREADS; i++) begin : g_im_addr
    assign im_addr_o[i*ADDR_W +: ADDR_W] = pc_q[i] >> 2;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      last_q  <= TID_W'(N_THREADS - 1);
      for (int i = 0; i < N_THREADS; i++) begin
        pc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: doc/sr_fetch_sched.md
Name: sr_fetch_sched

Overview:
- Parametrised multi-thread instruction fetch scheduler for the single-cycle core; successor to the two-stream instruction arbiter.
- Holds one PC per hardware thread and presents one instruction per cycle to decode.
- Issue order is round-robin or fixed-priority among threads that are enabled and have valid instruction data.
- Applies branch redirects or PC+4 only to the thread that issued.

Parameters:
- N_THREADS, 2, number of hardware threads (2..8).
- ADDR_W, 32, PC width in bits.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- NOP_INSTR, 32'h00000013, instruction driven when nothing issues.
- localparam TID_W = max(1, clog2(N_THREADS)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_addr  in  N_THREADS*ADDR_W  per-thread boot byte address; thread i is slice i.
- thr_en  in  N_THREADS  thread enable.
- im_addr  out  N_THREADS*ADDR_W  per-thread word address to instruction memory, equal to pc[i]>>2.
- im_data  in  N_THREADS*32  per-thread instruction word.
- im_valid  in  N_THREADS  per-thread instruction data valid.
- stall  in  1  core hold; suppresses issue.
- br_taken  in  1  redirect the thread issued this cycle.
- br_target  in  ADDR_W  redirect byte address.
- instr  out  32  issued instruction.
- instr_valid  out  1  instr is live this cycle.
- instr_tid  out  TID_W  issuing thread.
- instr_pc  out  ADDR_W  byte PC of the issued instruction.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All pc[i] <= 0, state <= INIT.
  - Round-robin pointer last <= N_THREADS-1, so thread 0 issues first.
  - Outputs: instr_valid=0, instr=NOP_INSTR, instr_tid=0, instr_pc=0, im_addr all 0.
  - The same applies if reset is asserted mid-run; an in-flight issue is discarded.
- FSM states INIT and RUN:
  - INIT lasts one clk after reset release. pc[i] <= start_addr[i] for all i. instr_valid=0. Next state is RUN.
  - RUN is permanent until the next reset.
- Eligibility: elig[i] = thr_en[i] & im_valid[i], evaluated in RUN only.
- Grant (combinational, same cycle):
  - ARB_MODE=0: first eligible index scanning last+1, last+2, ..., wrapping modulo N_THREADS.
  - ARB_MODE=1: lowest eligible index.
- Outputs in RUN:
  - instr_valid = |elig & ~stall.
  - With a grant: instr = im_data[g], instr_tid = g, instr_pc = pc[g]. These outputs are also driven during stall; only instr_valid drops.
  - With no eligible thread: instr=NOP_INSTR, instr_tid=last, instr_pc=pc[last].
- Latency: zero cycles. im_data to instr is combinational. PC update takes effect on the next clk edge.
- Update on clk when instr_valid=1:
  - pc[g] <= br_taken ? {br_target[ADDR_W-1:2],2'b00} : pc[g]+4. The +4 wraps modulo 2^ADDR_W.
  - last <= g.
  - All other pc[j] are unchanged.
- When instr_valid=0 (stall, no eligible thread, or INIT):
  - No PC changes and last is unchanged.
  - br_taken and br_target are ignored.
- Simultaneous events:
  - stall=1 together with br_taken=1: the redirect is ignored; the core must re-present it.
  - A thread whose thr_en drops keeps its PC and resumes from it when re-enabled.
  - thr_en changes in INIT have no effect on PC loading.
- The round-robin guarantees that every continuously eligible thread issues within N_THREADS valid cycles. Fixed-priority mode gives no fairness guarantee.
- im_addr[i] is always driven from pc[i] regardless of eligibility.

Test Plan:
- Round-robin alternation: N=2, start_addr={0x100,0x000}, all enabled and valid → after the INIT cycle, issues go (tid,pc) = (0,0x0),(1,0x100),(0,0x4),(1,0x104); im_addr[1] goes 0x40→0x41.
- Disabled thread: thr_en=2'b01 → only tid 0 issues, at pc 0x0, 0x4, 0x8 on consecutive cycles; pc[1] stays 0x100; then thr_en=2'b11 → tid 1 issues at 0x100 next.
- Branch redirect: br_taken=1, br_target=0x43 on a tid1 issue → tid1 next issues at 0x40; tid0 continues at PC+4 unaffected.
- Stall: stall=1 for 3 cycles with br_taken=1 → instr_valid=0 for 3 cycles, no PC or pointer change; after release the same tid and pc issue.
- Starvation edge:
  - im_valid=0 for all threads → instr_valid=0 and instr=32'h00000013; br_taken pulses are ignored.
  - ARB_MODE=1, N=4, all eligible → tid 0 issues every cycle.
- Reset mid-run: assert rst_n=0 asynchronously between edges → outputs go to reset values immediately; after release, one INIT cycle with instr_valid=0, then tid 0 issues at start_addr[0].
